// File: rtl/fsk_modulator.sv
// fsk_modulator: UART-framed binary-FSK transmitter with a continuous-phase mark idle tone.
// Defining FSK_MODULATOR_PARITY_EN inserts an even-parity bit between the data bits and stop.
module fsk_modulator #(
    parameter int HALF_PERIOD_0        = 100,
    parameter int HALF_PERIOD_1        = 60,
    parameter int HALF_PERIODS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       fsk_out,
    output logic       busy
);
    localparam int CW = $clog2(HALF_PERIOD_0);
    localparam int IW = (HALF_PERIODS_PER_BIT > 1) ? $clog2(HALF_PERIODS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_0  = CW'(HALF_PERIOD_0 - 1);
    localparam logic [CW-1:0] LAST_1  = CW'(HALF_PERIOD_1 - 1);
    localparam logic [IW-1:0] LAST_HP = IW'(HALF_PERIODS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
`ifdef FSK_MODULATOR_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] hp_cnt_q, hp_cnt_d;
    logic [IW-1:0] hp_idx_q, hp_idx_d;
    logic          fsk_q, fsk_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          pend_q, pend_d;
`ifdef FSK_MODULATOR_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic cur_bit;
    logic hp_end;
    logic bit_end;
    logic accept;

    // The current bit only changes on half-period boundaries, so HP is stable for a whole half-period.
    always_comb begin
        cur_bit = 1'b1;
        case (state_q)
            S_START:  cur_bit = 1'b0;
            S_DATA:   cur_bit = shift_q[0];
`ifdef FSK_MODULATOR_PARITY_EN
            S_PARITY: cur_bit = parity_q;
`endif
            default:  cur_bit = 1'b1;
        endcase
        hp_end   = (hp_cnt_q == (cur_bit ? LAST_1 : LAST_0));
        bit_end  = hp_end && (hp_idx_q == LAST_HP);
        busy     = !((state_q == S_IDLE) || (state_q == S_ARM));
        tx_ready = (state_q == S_IDLE) ||
                   ((state_q == S_STOP) && (hp_idx_q == LAST_HP) && !pend_q);
        accept   = tx_valid && tx_ready;
        fsk_out  = fsk_q;
    end

    always_comb begin
        state_d   = state_q;
        hp_cnt_d  = hp_end ? '0 : hp_cnt_q + 1'b1;
        hp_idx_d  = hp_idx_q;
        fsk_d     = fsk_q ^ hp_end;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        pend_d    = pend_q;
`ifdef FSK_MODULATOR_PARITY_EN
        parity_d  = parity_q;
`endif
        if (hp_end) begin
            hp_idx_d = (!busy || (hp_idx_q == LAST_HP)) ? '0 : hp_idx_q + 1'b1;
        end
        if (accept) begin
            shift_d = tx_data;
            pend_d  = 1'b1;
`ifdef FSK_MODULATOR_PARITY_EN
            parity_d = ^tx_data;
`endif
        end
        // An accept that lands on the last cycle of a mark half-period skips ARM entirely.
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (hp_end) begin
                        state_d = S_START;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                if (hp_end) begin
                    state_d = S_START;
                    pend_d  = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef FSK_MODULATOR_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef FSK_MODULATOR_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (pend_q || accept) begin
                        state_d = S_START;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hp_cnt_q  <= '0;
            hp_idx_q  <= '0;
            fsk_q     <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            pend_q    <= 1'b0;
`ifdef FSK_MODULATOR_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hp_cnt_q  <= hp_cnt_d;
            hp_idx_q  <= hp_idx_d;
            fsk_q     <= fsk_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            pend_q    <= pend_d;
`ifdef FSK_MODULATOR_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: doc/fsk_modulator.md
Name: fsk_modulator

Overview:
- Binary-FSK transmitter; the transmit-side counterpart of the ultrasonic link's period-measuring FSK demodulator.
- Accepts bytes over a valid/ready handshake and frames them UART-style: start bit 0, 8 data bits LSB first, stop bit 1.
- Emits each bit as a square wave whose half-period length encodes the bit; drives the ultrasonic transducer front end.
- Idle line carries a continuous mark (bit 1) tone, so the receiver holds 1 between frames.

Parameters:
- HALF_PERIOD_0, 100, clk cycles per half-period for bit 0 (space); must be > demod threshold/periods, >= 2.
- HALF_PERIOD_1, 60, clk cycles per half-period for bit 1 (mark); must be < HALF_PERIOD_0, >= 2.
- HALF_PERIODS_PER_BIT, 4, half-periods (fsk_out toggles) per bit; >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tx_data  input  8  byte to transmit
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  block can accept a byte this cycle
- fsk_out  output  1  FSK square-wave output
- busy  output  1  frame (start..stop) in progress

Behaviour:
- Reset (async assert, sync deassert use): fsk_out=0, busy=0, tx_ready=1, state IDLE, all counters 0, shift register 0. Reset mid-frame aborts immediately, with no partial-bit completion.
- Half-period counter hp_cnt, width $clog2(HALF_PERIOD_0). Current half-period length HP = HALF_PERIOD_0 if current bit=0, else HALF_PERIOD_1. HP is latched at the start of each half-period, never changed mid-half-period.
- hp_cnt counts 0..HP-1. On hp_cnt==HP-1: fsk_out toggles, hp_cnt<=0, hp_idx increments. Each half-period is exactly HP cycles.
- Bit boundary: the half-period ending with hp_idx==HALF_PERIODS_PER_BIT-1. Bit duration is HALF_PERIODS_PER_BIT*HP cycles.
- States:
  - IDLE: mark tone runs continuously (HP=HALF_PERIOD_1, hp_idx ignored); tx_ready=1, busy=0.
  - On tx_valid&tx_ready: latch tx_data and go to ARM. tx_ready=0 from the next cycle.
  - ARM: finish the current mark half-period, then enter START with hp_cnt=0, hp_idx=0. Start latency after accept is <= HALF_PERIOD_1 cycles.
  - START: one bit of 0. Then DATA.
  - DATA: 8 bits, shift register LSB first, bit counter 0..7. Then STOP.
  - STOP: one bit of 1.
  - At the STOP bit boundary: if a byte is latched go straight to START (no gap), else go to IDLE.
- busy=1 in START/DATA/STOP (and PARITY), 0 in IDLE/ARM.
- tx_ready=1 in IDLE and during the final half-period of STOP. A byte accepted during STOP is latched and starts with zero idle gap; tx_ready then drops.
- tx_valid without tx_ready: ignored, tx_data not sampled. Holding tx_valid high streams back-to-back frames.
- fsk_out is registered; no combinational path from inputs.
- Phase is continuous: fsk_out never glitches or double-toggles at bit or state transitions.

Optional Feature:
- Macro: FSK_MODULATOR_PARITY_EN.
- When defined: a PARITY state between DATA and STOP sends even parity (XOR of the 8 data bits). Frame is 11 bits.
- When undefined: no PARITY state, frame is 10 bits, and no parity logic is synthesized.

Test Plan:
- Reset then idle, defaults: fsk_out toggles every 60 cycles; tx_ready=1, busy=0. Assert rst_n=0 mid-half-period -> fsk_out=0 the same cycle.
- Send 0x55 with defaults, parity off:
  - start bit = 400 cycles of 100-cycle half-periods;
  - data bits 1,0,1,0,1,0,1,0 = 4*240 + 4*400 cycles;
  - stop = 240 cycles;
  - busy high for exactly 3200 cycles.
- Send 0x00 then 0xFF with tx_valid held high: second start bit begins the cycle after the first stop ends, with no mark gap; exactly 2 accepts observed.
- tx_valid pulsed while busy and not in the final STOP half-period -> not accepted, frame unchanged, tx_ready=0.
- Loopback into the demodulator (PERIODS_TO_MEASURE=2, threshold 160): bytes 0xA5, 0x3C, 0x00, 0xFF recovered bit-exact.
- With FSK_MODULATOR_PARITY_EN, send 0x07 -> parity bit 1 (240 cycles) before stop; send 0x03 -> parity bit 0 (400 cycles); frame = 11 bits.
